// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: sprite DMA bus initiator.
// A CPU write of page P to DMA_REG_ADDR halts the CPU. The block then copies
// XFER_LEN bytes from P00.. to OAM_DATA_ADDR as read/write pairs through the
// memory controller's request port.
// All outputs are registered. The action listed for a state becomes visible in
// the cycle after that state: a strobe decided in RD_REQ/WR_REQ is high during
// RD_GAP/WR_GAP, which is also the cycle whose mc_idle is ignored.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] trig_addr,
  input  logic [7:0]  trig_data,
  input  logic        trig_write_en,
  output logic        cpu_halt,
  output logic [15:0] mc_addr,
  output logic [7:0]  mc_data_out,
  output logic        mc_write_en,
  output logic        mc_read_en,
  input  logic [7:0]  mc_data_in,
  input  logic        mc_idle,
  output logic        dma_done,
  output logic [8:0]  byte_cnt
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ALIGN,
    S_RD_REQ,
    S_RD_GAP,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_GAP,
    S_WR_WAIT,
    S_DONE
  } state_t;

  localparam logic [8:0] LAST_CNT = 9'(XFER_LEN);

  state_t     state_reg;
  logic [7:0] page_reg;
  logic [7:0] data_reg;
  logic [8:0] cnt_next;

  // Count after the write that is completing now.
  assign cnt_next = byte_cnt + 9'd1;

  // Transfer sequencer with registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      page_reg    <= 8'd0;
      data_reg    <= 8'd0;
      cpu_halt    <= 1'b0;
      mc_addr     <= 16'd0;
      mc_data_out <= 8'd0;
      mc_write_en <= 1'b0;
      mc_read_en  <= 1'b0;
      dma_done    <= 1'b0;
      byte_cnt    <= 9'd0;
    end else begin
      // Strobes and the done flag are single-cycle pulses.
      mc_read_en  <= 1'b0;
      mc_write_en <= 1'b0;
      dma_done    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (trig_write_en && (trig_addr == DMA_REG_ADDR)) begin
            page_reg  <= trig_data;
            cpu_halt  <= 1'b1;
            byte_cnt  <= 9'd0;
            state_reg <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          state_reg <= S_RD_REQ;
        end
        S_RD_REQ: begin
          if (mc_idle) begin
            // The page never increments: the low byte alone walks 00..FF.
            mc_addr    <= {page_reg, byte_cnt[7:0]};
            mc_read_en <= 1'b1;
            state_reg  <= S_RD_GAP;
          end
        end
        S_RD_GAP: begin
          state_reg <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (mc_idle) begin
            data_reg  <= mc_data_in;
            state_reg <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (mc_idle) begin
            mc_addr     <= OAM_DATA_ADDR;
            mc_data_out <= data_reg;
            mc_write_en <= 1'b1;
            state_reg   <= S_WR_GAP;
          end
        end
        S_WR_GAP: begin
          state_reg <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (mc_idle) begin
            byte_cnt <= cnt_next;
            if (cnt_next == LAST_CNT) begin
              state_reg <= S_DONE;
            end else begin
              state_reg <= S_RD_REQ;
            end
          end
        end
        S_DONE: begin
          dma_done  <= 1'b1;
          cpu_halt  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
